// File: rtl/bp_stream_host_router.sv
// bp_stream_host_router
//   Inbound : host write stream (addr/data) is decoded to one of num_ch_p
//             channels and buffered in a per-channel FIFO. A control address
//             clears the unmapped-write status; other addresses are unmapped.
//   Outbound: per-channel return streams are merged round-robin into a single
//             registered host read stream tagged with the source channel.
//   Optional: define BP_STREAM_HOST_ROUTER_ERR_RESP_EN to return an error word
//             (tag num_ch_p) for every unmapped write instead of dropping it.
module bp_stream_host_router #(
    parameter int num_ch_p = 2,
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter logic [stream_addr_width_p-1:0] base_addr_p = 32'h10,
    parameter logic [stream_addr_width_p-1:0] addr_stride_p = 32'h10,
    parameter logic [stream_addr_width_p-1:0] ctrl_addr_p = 32'h0,
    parameter int fifo_els_p = 4,
    parameter int cnt_width_p = 16,
    localparam int lg_ch_lp = $clog2(num_ch_p + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    stream_v_i,
    input  logic [stream_addr_width_p-1:0]          stream_addr_i,
    input  logic [stream_data_width_p-1:0]          stream_data_i,
    output logic                                    stream_yumi_o,
    output logic [num_ch_p-1:0]                     ch_v_o,
    output logic [num_ch_p*stream_data_width_p-1:0] ch_data_o,
    input  logic [num_ch_p-1:0]                     ch_ready_i,
    input  logic [num_ch_p-1:0]                     ch_v_i,
    input  logic [num_ch_p*stream_data_width_p-1:0] ch_data_i,
    output logic [num_ch_p-1:0]                     ch_yumi_o,
    output logic                                    stream_v_o,
    output logic [stream_data_width_p-1:0]          stream_data_o,
    output logic [lg_ch_lp-1:0]                     stream_ch_o,
    input  logic                                    stream_ready_i,
    output logic [cnt_width_p-1:0]                  unmapped_cnt_o,
    output logic                                    unmapped_err_o
);

    localparam int dw_lp     = stream_data_width_p;
    localparam int lg_els_lp = $clog2(fifo_els_p);

    typedef logic [lg_els_lp:0] ptr_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [num_ch_p-1:0] hit_s;
    logic [num_ch_p-1:0] full_s;
    logic [num_ch_p-1:0] empty_s;
    logic [num_ch_p-1:0] enq_s;
    logic [num_ch_p-1:0] deq_s;
    logic                ctrl_s;
    logic                unmapped_s;
    logic                unm_take_s;
    logic                err_resp_s;
    logic                loadable_s;

    // Control and unmapped classification; a channel hit always wins.
    always_comb begin
        ctrl_s     = 1'b0;
        unmapped_s = 1'b0;
        if (stream_v_i && (hit_s == '0)) begin
            if (stream_addr_i == ctrl_addr_p) begin
                ctrl_s = 1'b1;
            end else begin
                unmapped_s = 1'b1;
            end
        end else begin
            ctrl_s     = 1'b0;
            unmapped_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel inbound FIFOs (circular buffer, pointers carry a wrap bit)
    // ------------------------------------------------------------------
    for (genvar g = 0; g < num_ch_p; g++) begin : g_ch
        localparam logic [stream_addr_width_p-1:0] ch_addr_lp =
            base_addr_p + (addr_stride_p * stream_addr_width_p'(g));

        logic [dw_lp-1:0] mem_q [fifo_els_p];
        ptr_t             wptr_q;
        ptr_t             wptr_d;
        ptr_t             rptr_q;
        ptr_t             rptr_d;

        assign hit_s[g]   = stream_v_i & (stream_addr_i == ch_addr_lp);
        assign full_s[g]  = (wptr_q[lg_els_lp] != rptr_q[lg_els_lp]) &&
                            (wptr_q[lg_els_lp-1:0] == rptr_q[lg_els_lp-1:0]);
        assign empty_s[g] = (wptr_q == rptr_q);
        // Fullness is judged before this cycle's dequeue.
        assign enq_s[g]   = hit_s[g] & ~full_s[g];
        assign deq_s[g]   = ~empty_s[g] & ch_ready_i[g];

        assign ch_v_o[g]                  = ~empty_s[g];
        assign ch_data_o[g*dw_lp +: dw_lp] = mem_q[rptr_q[lg_els_lp-1:0]];

        // Pointer advance on enqueue/dequeue.
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (enq_s[g]) begin
                wptr_d = wptr_q + ptr_t'(1'b1);
            end else begin
                wptr_d = wptr_q;
            end
            if (deq_s[g]) begin
                rptr_d = rptr_q + ptr_t'(1'b1);
            end else begin
                rptr_d = rptr_q;
            end
        end

        // Pointer registers; reset empties the FIFO.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
            end
        end

        // Storage array; contents are only meaningful below the write pointer.
        always_ff @(posedge clk_i) begin
            if (enq_s[g]) begin
                mem_q[wptr_q[lg_els_lp-1:0]] <= stream_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Unmapped-write handling
    // ------------------------------------------------------------------
`ifdef BP_STREAM_HOST_ROUTER_ERR_RESP_EN
    // An unmapped write needs the output register for its error word.
    assign err_resp_s = unmapped_s & loadable_s;
    assign unm_take_s = err_resp_s;
`else
    assign err_resp_s = 1'b0;
    assign unm_take_s = unmapped_s;
`endif

    // Host write is consumed by an accepted enqueue, a control write or a
    // taken unmapped write; forced low while reset is asserted.
    assign stream_yumi_o = reset_n_i & ((|enq_s) | ctrl_s | unm_take_s);

    logic [cnt_width_p-1:0] cnt_q;
    logic [cnt_width_p-1:0] cnt_d;
    logic                   err_q;
    logic                   err_d;

    // Saturating unmapped counter and sticky flag, cleared by control bit 0.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (ctrl_s && stream_data_i[0]) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (unm_take_s) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + cnt_width_p'(1'b1);
            end else begin
                cnt_d = cnt_q;
            end
            err_d = 1'b1;
        end else begin
            cnt_d = cnt_q;
            err_d = err_q;
        end
    end

    // Unmapped status registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign unmapped_cnt_o = cnt_q;
    assign unmapped_err_o = err_q;

    // ------------------------------------------------------------------
    // Outbound round-robin merge into a single output register
    // ------------------------------------------------------------------
    logic                out_v_q;
    logic                out_v_d;
    logic [dw_lp-1:0]    out_data_q;
    logic [dw_lp-1:0]    out_data_d;
    logic [lg_ch_lp-1:0] out_ch_q;
    logic [lg_ch_lp-1:0] out_ch_d;
    logic [lg_ch_lp-1:0] rr_q;
    logic [lg_ch_lp-1:0] rr_d;

    logic                grant_v_s;
    logic [lg_ch_lp-1:0] grant_idx_s;
    logic [num_ch_p-1:0] grant_oh_s;
    logic [dw_lp-1:0]    grant_data_s;

    assign loadable_s = ~out_v_q | stream_ready_i;

    // First valid channel at or after the pointer: scan the upper part of
    // the ring first, then wrap to the lower part.
    always_comb begin
        grant_v_s    = 1'b0;
        grant_idx_s  = '0;
        grant_oh_s   = '0;
        grant_data_s = '0;
        if (loadable_s && !err_resp_s) begin
            for (int j = 0; j < num_ch_p; j++) begin
                if (!grant_v_s && ch_v_i[j] && (lg_ch_lp'(j) >= rr_q)) begin
                    grant_v_s     = 1'b1;
                    grant_idx_s   = lg_ch_lp'(j);
                    grant_oh_s[j] = 1'b1;
                    grant_data_s  = ch_data_i[j*dw_lp +: dw_lp];
                end
            end
            for (int j = 0; j < num_ch_p; j++) begin
                if (!grant_v_s && ch_v_i[j]) begin
                    grant_v_s     = 1'b1;
                    grant_idx_s   = lg_ch_lp'(j);
                    grant_oh_s[j] = 1'b1;
                    grant_data_s  = ch_data_i[j*dw_lp +: dw_lp];
                end
            end
        end else begin
            grant_v_s = 1'b0;
        end
    end

    assign ch_yumi_o = grant_oh_s & {num_ch_p{reset_n_i}};

    // Output register load/drain and pointer update.
    always_comb begin
        out_v_d    = out_v_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        rr_d       = rr_q;
        if (err_resp_s) begin
            out_v_d    = 1'b1;
`ifdef BP_STREAM_HOST_ROUTER_ERR_RESP_EN
            out_data_d = {8'hEE, stream_addr_i[dw_lp-9:0]};
`else
            out_data_d = out_data_q;
`endif
            out_ch_d   = lg_ch_lp'(num_ch_p);
        end else if (grant_v_s) begin
            out_v_d    = 1'b1;
            out_data_d = grant_data_s;
            out_ch_d   = grant_idx_s;
            if (grant_idx_s == lg_ch_lp'(num_ch_p - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant_idx_s + lg_ch_lp'(1'b1);
            end
        end else if (loadable_s) begin
            out_v_d = 1'b0;
        end else begin
            out_v_d = out_v_q;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            rr_q       <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            rr_q       <= rr_d;
        end
    end

    assign stream_v_o    = out_v_q;
    assign stream_data_o = out_data_q;
    assign stream_ch_o   = out_ch_q;

endmodule
